// File: rtl/wb_write_queue.sv
// Dual-lane writeback queue: buffers up to DEPTH register-file writes from two
// issue lanes, retires one per cycle in order, and answers youngest-pending hazard queries.
module wb_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     v0,
    input  logic [4:0]               rd0,
    input  logic [31:0]              d0,
    input  logic                     v1,
    input  logic [4:0]               rd1,
    input  logic [31:0]              d1,
    output logic                     in_ready,
    output logic                     we,
    output logic [4:0]               rw,
    output logic [31:0]              inW,
    input  logic [4:0]               q_reg,
    output logic                     q_hit,
    output logic [31:0]              q_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head_reg;
    logic [AW-1:0] tail_reg;
    logic [CW-1:0] count_reg;
    logic [AW-1:0] head_next;
    logic [AW-1:0] tail_next;
    logic [CW-1:0] count_next;

    logic [4:0]    rd_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic          acc0;
    logic          acc1;
    logic          deq;
    logic [AW-1:0] tail1;

    // Producers are only ever let in when two free slots exist, so the
    // occupancy can never overflow even with a simultaneous dual enqueue.
    assign in_ready = (count_reg <= CW'(DEPTH - 2));
    assign acc0     = in_ready && v0 && (rd0 != 5'd0);
    assign acc1     = in_ready && v1 && (rd1 != 5'd0);
    assign deq      = (count_reg != '0);

    // Lane 1 lands right behind lane 0, or at the tail itself when lane 0 is absent.
    assign tail1      = tail_reg + AW'(acc0);
    assign tail_next  = tail_reg + AW'(acc0) + AW'(acc1);
    assign head_next  = head_reg + AW'(deq);
    assign count_next = count_reg + CW'(acc0) + CW'(acc1) - CW'(deq);

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (acc0) begin
                rd_mem[tail_reg]   <= rd0;
                data_mem[tail_reg] <= d0;
            end
            if (acc1) begin
                rd_mem[tail1]   <= rd1;
                data_mem[tail1] <= d1;
            end
        end
    end

    assign count = count_reg;
    assign we    = deq;
    assign rw    = deq ? rd_mem[head_reg]   : 5'd0;
    assign inW   = deq ? data_mem[head_reg] : 32'd0;

    // Hazard lookup indexed by age offset from head. Offset 0 is always the
    // entry being written this cycle, so it never counts as pending.
    logic [DEPTH-1:0] match;
    logic [31:0]      slot_data [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [AW-1:0] idx;
            assign idx           = head_reg + AW'(gi);
            assign slot_data[gi] = data_mem[idx];
            if (gi == 0) begin : g_head
                assign match[gi] = 1'b0;
            end else begin : g_body
                assign match[gi] = (CW'(gi) < count_reg) && (rd_mem[idx] == q_reg);
            end
        end
    endgenerate

    always_comb begin
        q_hit  = 1'b0;
        q_data = 32'd0;
        if (q_reg != 5'd0) begin
            // Later offsets are younger, so the last match found wins.
            for (int j = 1; j < DEPTH; j++) begin
                if (match[j]) begin
                    q_hit  = 1'b1;
                    q_data = slot_data[j];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: queue-based reference model checked every cycle,
// plus directed scenario tasks with their own inline checks.
module tb_wb_write_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          v0, v1;
    logic [4:0]    rd0, rd1, q_reg;
    logic [31:0]   d0, d1;
    logic          in_ready, we, q_hit;
    logic [4:0]    rw;
    logic [31:0]   inW, q_data;
    logic [CW-1:0] count;

    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 1'b0;
    int            peak   = 0;
    logic [36:0]   sb [$];

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .v0(v0), .rd0(rd0), .d0(d0),
        .v1(v1), .rd1(rd1), .d1(d1),
        .in_ready(in_ready), .we(we), .rw(rw), .inW(inW),
        .q_reg(q_reg), .q_hit(q_hit), .q_data(q_data), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: the queue holds {rd, data} in drain order.
    always @(posedge clk) begin
        bit rdy;
        if (rst) begin
            sb.delete();
        end else begin
            rdy = (sb.size() <= DEPTH - 2);
            if (sb.size() != 0) void'(sb.pop_front());
            if (rdy && v0 && rd0 != 5'd0) sb.push_back({rd0, d0});
            if (rdy && v1 && rd1 != 5'd0) sb.push_back({rd1, d1});
        end
    end

    // Per-cycle scoreboard comparison of every output against the model.
    always @(negedge clk) begin
        logic [4:0]  e_rw;
        logic [31:0] e_inw;
        logic        e_hit;
        logic [31:0] e_qd;
        if (mon_en && !rst) begin
            e_rw  = 5'd0;
            e_inw = 32'd0;
            if (sb.size() != 0) begin
                e_rw  = sb[0][36:32];
                e_inw = sb[0][31:0];
            end
            e_hit = 1'b0;
            e_qd  = 32'd0;
            for (int i = 1; i < sb.size(); i++) begin
                if (q_reg != 5'd0 && sb[i][36:32] == q_reg) begin
                    e_hit = 1'b1;
                    e_qd  = sb[i][31:0];
                end
            end
            checks++;
            if (count !== CW'(sb.size())) begin
                errors++;
                $display("FAIL mon_count: got %0d expected %0d", count, sb.size());
            end
            checks++;
            if (we !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL mon_we: got %b expected %b", we, sb.size() != 0);
            end
            checks++;
            if (rw !== e_rw || inW !== e_inw) begin
                errors++;
                $display("FAIL mon_write: got rw=%0d inW=%h expected rw=%0d inW=%h", rw, inW, e_rw, e_inw);
            end
            checks++;
            if (in_ready !== (sb.size() <= DEPTH - 2)) begin
                errors++;
                $display("FAIL mon_in_ready: got %b expected %b", in_ready, sb.size() <= DEPTH - 2);
            end
            checks++;
            if (q_hit !== e_hit || q_data !== e_qd) begin
                errors++;
                $display("FAIL mon_query: q_reg=%0d got hit=%b data=%h expected hit=%b data=%h",
                         q_reg, q_hit, q_data, e_hit, e_qd);
            end
            if (int'(count) > peak) peak = int'(count);
            if (we) $display("write rw=%0d inW=%h count=%0d", rw, inW, count);
        end
    end

    task automatic idle_inputs();
        v0 = 1'b0; rd0 = 5'd0; d0 = 32'd0;
        v1 = 1'b0; rd1 = 5'd0; d1 = 32'd0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d entries left expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (we !== 1'b0 || rw !== 5'd0 || inW !== 32'd0) begin
            errors++;
            $display("FAIL reset_write: got we=%b rw=%0d inW=%h expected 0/0/0", we, rw, inW);
        end
        checks++;
        if (q_hit !== 1'b0 || q_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_query: got hit=%b data=%h expected 0/0", q_hit, q_data);
        end
        checks++;
        if (in_ready !== 1'b1 || count !== '0) begin
            errors++;
            $display("FAIL reset_state: got in_ready=%b count=%0d expected 1/0", in_ready, count);
        end
        $display("reset done");
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        v0 = 1'b1; rd0 = 5'd5; d0 = 32'hAAAA0001;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (we !== 1'b1 || rw !== 5'd5 || inW !== 32'hAAAA0001) begin
            errors++;
            $display("FAIL single_write: got we=%b rw=%0d inW=%h expected 1/5/aaaa0001", we, rw, inW);
        end
        @(negedge clk);
        checks++;
        if (we !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL single_empty: got we=%b count=%0d expected 0/0", we, count);
        end
    endtask

    task automatic test_same_cycle();
        @(posedge clk); #1;
        v0 = 1'b1; rd0 = 5'd3; d0 = 32'h11;
        v1 = 1'b1; rd1 = 5'd3; d1 = 32'h22;
        @(posedge clk); #1;
        idle_inputs();
        q_reg = 5'd3;
        @(negedge clk);
        checks++;
        if (q_hit !== 1'b1 || q_data !== 32'h22) begin
            errors++;
            $display("FAIL pair_query: got hit=%b data=%h expected 1/22", q_hit, q_data);
        end
        checks++;
        if (rw !== 5'd3 || inW !== 32'h11) begin
            errors++;
            $display("FAIL pair_first: got rw=%0d inW=%h expected 3/11", rw, inW);
        end
        @(negedge clk);
        checks++;
        if (rw !== 5'd3 || inW !== 32'h22 || q_hit !== 1'b0) begin
            errors++;
            $display("FAIL pair_second: got rw=%0d inW=%h hit=%b expected 3/22/0", rw, inW, q_hit);
        end
        wait_drain();
        q_reg = 5'd0;
    endtask

    task automatic drive_pair(input int p);
        v0 = 1'b1; rd0 = 5'(2 * p + 1); d0 = 32'hB000_0000 + 32'(2 * p);
        v1 = 1'b1; rd1 = 5'(2 * p + 2); d1 = 32'hB000_0000 + 32'(2 * p + 1);
    endtask

    task automatic test_back_to_back();
        int p = 0;
        bit saw_block = 1'b0;
        peak  = 0;
        q_reg = 5'd4;
        @(posedge clk); #1;
        drive_pair(0);
        for (int cyc = 0; cyc < 20 && p < 3; cyc++) begin
            @(negedge clk);
            if (sb.size() <= DEPTH - 2) p++;
            else saw_block = 1'b1;
            @(posedge clk); #1;
            if (p < 3) drive_pair(p);
            else idle_inputs();
        end
        checks++;
        if (p != 3) begin
            errors++;
            $display("FAIL b2b_accept: got %0d pairs expected 3", p);
        end
        checks++;
        if (saw_block != 1'b1) begin
            errors++;
            $display("FAIL b2b_backpressure: got in_ready never low expected a stall");
        end
        wait_drain();
        checks++;
        if (peak != 3) begin
            errors++;
            $display("FAIL b2b_peak: got %0d expected 3", peak);
        end
        q_reg = 5'd0;
    endtask

    task automatic test_rd_zero();
        @(posedge clk); #1;
        v0 = 1'b1; rd0 = 5'd0; d0 = 32'hDEAD;
        v1 = 1'b1; rd1 = 5'd7; d1 = 32'h7;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (count !== CW'(1) || rw !== 5'd7 || inW !== 32'h7) begin
            errors++;
            $display("FAIL rd_zero: got count=%0d rw=%0d inW=%h expected 1/7/7", count, rw, inW);
        end
        wait_drain();
    endtask

    task automatic test_reset_flush();
        @(posedge clk); #1;
        drive_pair(4);
        @(posedge clk); #1;
        drive_pair(5);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (count !== CW'(3)) begin
            errors++;
            $display("FAIL flush_fill: got count=%0d expected 3", count);
        end
        @(posedge clk); #1;
        rst = 1'b1; v0 = 1'b1; rd0 = 5'd9; d0 = 32'h99;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (count !== '0 || we !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL flush_after: cycle %0d got count=%0d we=%b in_ready=%b expected 0/0/1",
                         i, count, we, in_ready);
            end
        end
    endtask

    task automatic test_stream();
        int n = 2 * DEPTH + 1;
        q_reg = 5'd1;
        @(posedge clk); #1;
        v0 = 1'b1; rd0 = 5'd1; d0 = 32'h1000;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i < n - 1) begin
                rd0 = 5'((i + 1) % 31 + 1);
                d0  = 32'h1000 + 32'(i + 1);
            end else begin
                idle_inputs();
            end
            @(negedge clk);
            checks++;
            if (count !== CW'(1) || we !== 1'b1 || inW !== 32'h1000 + 32'(i)) begin
                errors++;
                $display("FAIL stream: step %0d got count=%0d we=%b inW=%h expected 1/1/%h",
                         i, count, we, inW, 32'h1000 + 32'(i));
            end
        end
        wait_drain();
        q_reg = 5'd0;
    endtask

    initial begin
        rst   = 1'b1;
        q_reg = 5'd0;
        idle_inputs();
        test_reset();
        test_single();
        test_same_cycle();
        test_back_to_back();
        test_rd_zero();
        test_reset_flush();
        test_stream();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered write entries (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1, sole clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port v0, input, 1, lane-0 result valid (older instruction).
REQ-005 SHALL have port rd0, input, 5, lane-0 destination register.
REQ-006 SHALL have port d0, input, 32, lane-0 result data.
REQ-007 SHALL have port v1, input, 1, lane-1 result valid (younger instruction).
REQ-008 SHALL have port rd1, input, 5, lane-1 destination register.
REQ-009 SHALL have port d1, input, 32, lane-1 result data.
REQ-010 SHALL have port in_ready, output, 1, queue can accept two entries this cycle.
REQ-011 SHALL have port we, output, 1, register-file write enable.
REQ-012 SHALL have port rw, output, 5, register-file write address.
REQ-013 SHALL have port inW, output, 32, register-file write data.
REQ-014 SHALL have port q_reg, input, 5, hazard-query register number.
REQ-015 SHALL have port q_hit, output, 1, query register has a pending queued write.
REQ-016 SHALL have port q_data, output, 32, data of the youngest pending write to q_reg.
REQ-017 SHALL have port count, output, log2(DEPTH)+1, current occupancy.

Function
REQ-018 SHALL use one clock (clk) and a synchronous active-high reset (rst).
REQ-019 SHALL be a circular FIFO with head pointer, tail pointer and occupancy count; pointers wrap modulo DEPTH.
REQ-020 SHALL drive in_ready = (count <= DEPTH-2), combinationally from registered count.
REQ-021 SHALL accept lane inputs only in a cycle with in_ready=1; with in_ready=0, v0/v1 are ignored and producers hold their values.
REQ-022 SHALL discard any valid lane whose rd is 0; it is not enqueued and does not change count.
REQ-023 SHALL enqueue lane 0 before lane 1 in the same cycle, so lane 1 is younger; if only lane 1 is valid, it occupies a single slot.
REQ-024 SHALL drive we = (count != 0) and rw/inW = head entry, combinationally from registered state; with count = 0, rw = 0 and inW = 0.
REQ-025 SHALL retire exactly one entry per clock edge while count != 0, advancing head; writes drain in enqueue order.
REQ-026 SHALL, on simultaneous enqueue of k entries and dequeue, set next count = count + k - 1; count never exceeds DEPTH.
REQ-027 SHALL compute q_hit/q_data combinationally over the valid entries only, excluding the head when it retires this cycle, and selecting the youngest match.
REQ-028 SHALL force q_hit=0 and q_data=0 when q_reg=0 or no match exists.
REQ-029 SHALL provide a latency of one edge from acceptance to head for an empty queue: an entry accepted at edge N drives we=1 after edge N, and the write occurs at edge N+1.

Reset
REQ-030 SHALL, at an rst=1 edge, clear head, tail and count to 0 and discard all entries, giving we=0, rw=0, inW=0, q_hit=0, q_data=0 and in_ready=1 in the following cycle.
REQ-031 SHALL give rst priority over simultaneous enqueue and dequeue; inputs valid in a reset cycle are lost.

Verification
REQ-032 Reset, then v0=1 rd0=5 d0=0xAAAA0001 for one cycle -> next cycle we=1, rw=5, inW=0xAAAA0001; the cycle after, we=0 and count=0.
REQ-033 v0=1 rd0=3 d0=0x11 and v1=1 rd1=3 d1=0x22 in the same cycle, q_reg=3 -> q_hit=1, q_data=0x22; drain order rw=3/0x11 then rw=3/0x22.
REQ-034 Both lanes valid on 3 consecutive cycles with DEPTH=4 -> in_ready drops to 0 once count=3, the held third pair is accepted later, every entry is written once in order, and count never exceeds 4.
REQ-035 v0=1 rd0=0, v1=1 rd1=7 d1=0x7 -> only one entry is queued (count=1), and the only write is rw=7.
REQ-036 Three entries queued, then rst=1 for one cycle while v0=1 -> count=0, we=0 and in_ready=1 afterwards, with no write of the discarded entries.
REQ-037 Continuous single-lane traffic for 2*DEPTH+1 cycles -> pointers wrap, count stays at 1, and inW matches the input stream delayed one cycle.
